// File: rtl/ro_scan_scheduler_if.sv
// Byte-stream link from ro_scan_scheduler to the UART transmitter.
interface ro_scan_scheduler_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/ro_scan_scheduler.sv
// Ring-oscillator scan sequencer: settles, gates and captures each enabled RO, then
// streams {A,idx}, count_hi, count_lo to the UART. RO_SCAN_CHECKSUM_EN adds an XOR byte.
module ro_scan_scheduler #(
    parameter int unsigned N_OSC         = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_CYCLES   = 10000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic                cont,
    input  logic [N_OSC-1:0]    osc_mask,
    input  logic [CNT_W-1:0]    count,
    ro_scan_scheduler_if.master tx,
    output logic [N_OSC-1:0]    osc_en,
    output logic [1:0]          osc_sel,
    output logic                cnt_clr,
    output logic                cnt_en,
    output logic                busy,
    output logic                done
);

    localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CYC_W-1:0] SETTLE_INIT = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GATE_INIT   = CYC_W'(GATE_CYCLES - 1);
`ifdef RO_SCAN_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, CAPTURE, SEND, NEXT} state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [N_OSC-1:0] mask_q;
    logic [CYC_W-1:0] cyc;
    logic [15:0]      cap;
    logic [1:0]       bidx;
    logic             hold;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             lo_found;
    logic [1:0]       lo_idx;
    logic             nx_found;
    logic [1:0]       nx_idx;

    assign osc_sel     = idx;
    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;

    function automatic logic [N_OSC-1:0] onehot(input logic [1:0] n);
        logic [N_OSC-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_OSC; i++)
            v[i] = (32'(n) == i);
        return v;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] b, input logic [1:0] n,
                                              input logic [15:0] c);
        logic [7:0] hdr;
        logic [7:0] r;
        hdr = {4'hA, 2'b00, n};
        case (b)
            2'd0:    r = hdr;
            2'd1:    r = c[15:8];
            2'd2:    r = c[7:0];
`ifdef RO_SCAN_CHECKSUM_EN
            2'd3:    r = hdr ^ c[15:8] ^ c[7:0];
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Lowest set bit of the live mask (scan start) and next higher bit of the latched one.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        nx_found = 1'b0;
        nx_idx   = '0;
        for (int unsigned i = 0; i < N_OSC; i++) begin
            if (osc_mask[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 2'(i);
            end
            if (mask_q[i] && (i > 32'(idx)) && !nx_found) begin
                nx_found = 1'b1;
                nx_idx   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state      <= IDLE;
            idx        <= '0;
            mask_q     <= '0;
            cyc        <= '0;
            cap        <= '0;
            bidx       <= '0;
            hold       <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            osc_en     <= '0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt_clr    <= 1'b0;
            done       <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= osc_mask;
                        if (lo_found) begin
                            state   <= SETTLE;
                            idx     <= lo_idx;
                            osc_en  <= onehot(lo_idx);
                            cnt_clr <= 1'b1;
                            cyc     <= SETTLE_INIT;
                            busy    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cyc == '0) begin
                        state  <= GATE;
                        cnt_en <= 1'b1;
                        cyc    <= GATE_INIT;
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                GATE: begin
                    if (cyc == '0) begin
                        state  <= CAPTURE;
                        cnt_en <= 1'b0;
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                CAPTURE: begin
                    cap    <= 16'(count);
                    osc_en <= '0;
                    state  <= SEND;
                    bidx   <= '0;
                    hold   <= 1'b0;
                    // The header does not depend on cap, so byte 0 can go out on entry.
                    if (!tx.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= frame_byte(2'd0, idx, cap);
                    end
                end
                SEND: begin
                    if (tx_start_q) begin
                        if (bidx == LAST_BYTE) begin
                            state <= NEXT;
                        end else begin
                            bidx <= bidx + 2'd1;
                            hold <= 1'b1;
                        end
                    end else if (hold) begin
                        hold <= 1'b0;
                    end else if (!tx.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= frame_byte(bidx, idx, cap);
                    end
                end
                NEXT: begin
                    if (nx_found) begin
                        state   <= SETTLE;
                        idx     <= nx_idx;
                        osc_en  <= onehot(nx_idx);
                        cnt_clr <= 1'b1;
                        cyc     <= SETTLE_INIT;
                    end else begin
                        done <= 1'b1;
                        if (cont && lo_found) begin
                            mask_q  <= osc_mask;
                            state   <= SETTLE;
                            idx     <= lo_idx;
                            osc_en  <= onehot(lo_idx);
                            cnt_clr <= 1'b1;
                            cyc     <= SETTLE_INIT;
                        end else begin
                            if (cont)
                                mask_q <= osc_mask;
                            state <= IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_scan_scheduler.sv
// Directed/randomized bench for ro_scan_scheduler with a counter, UART busy model
// and a frame-level reference built from the mask and oscillator rates.
module tb_ro_scan_scheduler;
    localparam int unsigned G = 8;
    localparam int unsigned S = 2;
`ifdef RO_SCAN_CHECKSUM_EN
    localparam int FB = 4;
`else
    localparam int FB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [3:0]  osc_mask = '0;
    logic [15:0] count;
    logic [3:0]  osc_en;
    logic [1:0]  osc_sel;
    logic        cnt_clr, cnt_en, busy, done;

    ro_scan_scheduler_if txif ();

    ro_scan_scheduler #(
        .N_OSC(4), .CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont),
        .osc_mask(osc_mask), .count(count), .tx(txif),
        .osc_en(osc_en), .osc_sel(osc_sel), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor / environment state (written only by the negedge process)
    int          cyc = 0, done_cnt = 0, tx_cnt = 0, en_cycles = 0, viol = 0, sel_bad = 0;
    int          busy_rem = 0;
    logic [7:0]  rx[$];
    int          tx_cyc_q[$];
    int          clr_cyc_q[$];
    logic [3:0]  oen_q[$];
    logic [15:0] ctr = '0;

    // Environment controls (written only by the stimulus process)
    int          busy_len = 3;
    bit          force_busy = 1'b0;
    bit          fixed_mode = 1'b1;
    logic [15:0] fixed_val = '0;
    int unsigned rate[4] = '{default: 0};

    // Bookkeeping for the stimulus process
    int          rx_base, done_base, en_base, oen_base, clr_base, tx_base, s_cyc;
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (txif.tx_start) begin
            tx_cnt++;
            rx.push_back(txif.tx_data);
            tx_cyc_q.push_back(cyc);
            if (txif.tx_busy === 1'b1) viol++;
        end
        if (done) done_cnt++;
        if (cnt_en) en_cycles++;
        if (osc_en != 4'b0000 && osc_en != (4'b0001 << osc_sel)) sel_bad++;
        if (cnt_clr) begin
            clr_cyc_q.push_back(cyc);
            oen_q.push_back(osc_en);
            ctr = '0;
        end else if (cnt_en && osc_en[osc_sel]) begin
            ctr = ctr + 16'(rate[osc_sel]);
        end
        count = fixed_mode ? fixed_val : ctr;
        // UART model: busy for busy_len cycles starting the cycle after tx_start
        if (busy_rem > 0) begin
            txif.tx_busy = 1'b1;
            busy_rem--;
        end else begin
            txif.tx_busy = force_busy;
        end
        if (force_busy) txif.tx_busy = 1'b1;
        if (txif.tx_start) busy_rem = busy_len;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [3:0] m);
        logic [15:0] v;
        logic [7:0]  hdr;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                v   = fixed_mode ? fixed_val : 16'(G * rate[i]);
                hdr = 8'hA0 | 8'(i);
                exp_q.push_back(hdr);
                exp_q.push_back(v[15:8]);
                exp_q.push_back(v[7:0]);
`ifdef RO_SCAN_CHECKSUM_EN
                exp_q.push_back(hdr ^ v[15:8] ^ v[7:0]);
`endif
            end
        end
    endtask

    task automatic cmp_frames(input string tag);
        chk($sformatf("%s nbytes", tag), rx.size() - rx_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_base + i < rx.size())
                chk($sformatf("%s byte%0d", tag, i), rx[rx_base + i], exp_q[i]);
    endtask

    task automatic launch(input logic [3:0] m, input logic c);
        osc_mask  = m;
        cont      = c;
        rx_base   = rx.size();
        done_base = done_cnt;
        en_base   = en_cycles;
        oen_base  = oen_q.size();
        clr_base  = clr_cyc_q.size();
        tx_base   = tx_cnt;
        start     = 1'b1;
        s_cyc     = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk({tag, " done reached"}, 32'(done_cnt >= target), 1);
    endtask

    function automatic logic [31:0] outs();
        return 32'({osc_en, osc_sel, cnt_clr, cnt_en, txif.tx_start, txif.tx_data, busy, done});
    endfunction

    initial begin
        int lat, n, tx_at_abort, done_at_abort;
        logic [3:0] m;

        repeat (3) step();
        chk("reset outputs", outs(), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        chk("idle outputs", outs(), 0);

        // Two-oscillator scan with fixed count; also checks cycle timing
        fixed_mode = 1'b1;
        fixed_val  = 16'h1234;
        busy_len   = 3;
        exp_q.delete();
        build_exp(4'b0101);
        launch(4'b0101, 1'b0);
        wait_done("t1", done_base + 1, 400);
        repeat (3) step();
        cmp_frames("t1");
        chk("t1 done count", done_cnt - done_base, 1);
        chk("t1 busy after", busy, 0);
        chk("t1 osc_en after", osc_en, 0);
        chk("t1 clr count", clr_cyc_q.size() - clr_base, 2);
        chk("t1 osc_en first", (oen_q.size() > oen_base) ? oen_q[oen_base] : 4'hF, 4'b0001);
        chk("t1 osc_en second", (oen_q.size() > oen_base + 1) ? oen_q[oen_base + 1] : 4'hF, 4'b0100);
        lat = (tx_cyc_q.size() > rx_base) ? tx_cyc_q[rx_base] - s_cyc + 1 : -1;
        chk("t2 start to tx_start", lat, 1 + S + G + 1 + 1);
        lat = (clr_cyc_q.size() > clr_base) ? clr_cyc_q[clr_base] - s_cyc + 1 : -1;
        chk("t2 cnt_clr cycle", lat, 2);
        chk("t2 cnt_en cycles", en_cycles - en_base, 2 * G);

        // Empty mask
        launch(4'b0000, 1'b0);
        chk("t3 done pulse", done, 1);
        chk("t3 busy", busy, 0);
        step();
        chk("t3 done drop", done, 0);
        repeat (5) step();
        chk("t3 no tx", tx_cnt - tx_base, 0);
        chk("t3 done count", done_cnt - done_base, 1);
        chk("t3 busy still low", busy, 0);

        // Continuous mode, cleared in the middle of the third frame
        fixed_mode = 1'b0;
        rate[3]    = $urandom_range(1, 8000);
        busy_len   = 2;
        exp_q.delete();
        repeat (3) build_exp(4'b1000);
        launch(4'b1000, 1'b1);
        n = 0;
        while (rx.size() - rx_base < 2 * FB + 1 && n < 2000) begin
            step();
            n++;
        end
        cont = 1'b0;
        wait_done("t4", done_base + 3, 400);
        repeat (20) step();
        cmp_frames("t4");
        chk("t4 done count", done_cnt - done_base, 3);
        chk("t4 busy after", busy, 0);

        // Abort with ena during GATE
        for (int i = 0; i < 4; i++) rate[i] = $urandom_range(1, 8000);
        launch(4'($urandom_range(1, 15)), 1'b0);
        n = 0;
        while (!cnt_en && n < 50) begin
            step();
            n++;
        end
        chk("t5 reached gate", cnt_en, 1);
        repeat (3) step();
        ena = 1'b0;
        step();
        chk("t5 ena abort outputs", outs(), 0);
        ena = 1'b1;
        tx_at_abort = tx_cnt;
        repeat (20) step();
        chk("t5 no tx after abort", tx_cnt - tx_at_abort, 0);

        // Abort with rst_n during SEND after the first byte
        launch(4'($urandom_range(1, 15)), 1'b0);
        n = 0;
        while (rx.size() - rx_base < 1 && n < 100) begin
            step();
            n++;
        end
        step();
        rst_n = 1'b0;
        step();
        chk("t5 rst abort outputs", outs(), 0);
        rst_n = 1'b1;
        tx_at_abort   = tx_cnt;
        done_at_abort = done_cnt;
        repeat (30) step();
        chk("t5 no partial frame", tx_cnt - tx_at_abort, 0);
        chk("t5 no done after abort", done_cnt - done_at_abort, 0);

        // Clean randomized scans
        for (int k = 0; k < 5; k++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) rate[i] = $urandom_range(1, 8000);
            busy_len = $urandom_range(1, 5);
            exp_q.delete();
            build_exp(m);
            launch(m, 1'b0);
            wait_done($sformatf("rnd%0d", k), done_base + 1, 1000);
            repeat (3) step();
            cmp_frames($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d done count", k), done_cnt - done_base, 1);
            chk($sformatf("rnd%0d cnt_en cycles", k), en_cycles - en_base, G * $countones(m));
            chk($sformatf("rnd%0d busy after", k), busy, 0);
        end

        // Stuck tx_busy holds SEND; frame for idx 1 with cap BEEF afterwards
        fixed_mode = 1'b1;
        fixed_val  = 16'hBEEF;
        busy_len   = 3;
        force_busy = 1'b1;
        exp_q.delete();
        build_exp(4'b0010);
        launch(4'b0010, 1'b0);
        repeat (1 + S + G + 1 + 50) step();
        chk("t6 no tx while stuck", tx_cnt - tx_base, 0);
        chk("t6 busy while stuck", busy, 1);
        force_busy = 1'b0;
        wait_done("t6", done_base + 1, 200);
        repeat (3) step();
        cmp_frames("t6");
        chk("t6 header", (rx.size() > rx_base) ? rx[rx_base] : 8'h00, 8'hA1);
`ifdef RO_SCAN_CHECKSUM_EN
        chk("t6 checksum", (rx.size() > rx_base + 3) ? rx[rx_base + 3] : 8'h00, 8'hF0);
`endif

        chk("tx_start while tx_busy", viol, 0);
        chk("osc_sel tracks osc_en", sel_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
